// File: rtl/pipeline_stall_ctrl_if.sv
// rtl/pipeline_stall_ctrl_if.sv - hazard/stall request inputs and pipeline control outputs
interface pipeline_stall_ctrl_if #(
  parameter int NREGS = 8
);
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic             load_use_stall;
  logic             flush_req;
  logic             multi_start;
  logic [NREGS-1:0] multi_mask;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_rr_en;
  logic             id_rr_bubble;
  logic             multi_valid;
  logic [RW-1:0]    multi_reg;
  logic             multi_last;
  logic [31:0]      stall_cycles;
  logic [31:0]      flush_count;

  modport master (
    output load_use_stall, flush_req, multi_start, multi_mask,
    input  pc_en, if_id_en, if_id_flush, id_rr_en, id_rr_bubble,
    input  multi_valid, multi_reg, multi_last, stall_cycles, flush_count
  );

  modport slave (
    input  load_use_stall, flush_req, multi_start, multi_mask,
    output pc_en, if_id_en, if_id_flush, id_rr_en, id_rr_bubble,
    output multi_valid, multi_reg, multi_last, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline enables, bubbles, flush and LM/SM micro-op sequencer
// Optional perf counters built when PIPE_STALL_PERF_EN is defined.
module pipeline_stall_ctrl #(
  parameter int NREGS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_stall_ctrl_if.slave  bus
);
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic {RUN, MULTI} state_t;

  state_t           state;
  logic [NREGS-1:0] mask_q;
  logic [NREGS-1:0] mask_rest;
  logic [RW-1:0]    low_idx;
  logic             low_found;
  logic             is_last;

  // Lowest set bit is the next register to sequence; clearing it leaves the remainder.
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (mask_q[i] && !low_found) begin
        low_idx   = RW'(i);
        low_found = 1'b1;
      end
    end
    mask_rest = mask_q & (mask_q - NREGS'(1));
    is_last   = low_found && (mask_rest == '0);
  end

  always_comb begin
    bus.pc_en        = 1'b0;
    bus.if_id_en     = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_rr_en     = 1'b0;
    bus.id_rr_bubble = 1'b0;
    bus.multi_valid  = 1'b0;
    bus.multi_reg    = '0;
    bus.multi_last   = 1'b0;
    if (rst) begin
      bus.pc_en = 1'b0;
    end else if (bus.flush_req) begin
      bus.pc_en        = 1'b1;
      bus.if_id_en     = 1'b1;
      bus.if_id_flush  = 1'b1;
      bus.id_rr_en     = 1'b1;
      bus.id_rr_bubble = 1'b1;
    end else if (bus.load_use_stall) begin
      bus.id_rr_en     = 1'b1;
      bus.id_rr_bubble = 1'b1;
    end else if (state == RUN) begin
      if (bus.multi_start && (bus.multi_mask != '0)) begin
        bus.id_rr_en     = 1'b1;
        bus.id_rr_bubble = 1'b1;
      end else begin
        bus.pc_en    = 1'b1;
        bus.if_id_en = 1'b1;
        bus.id_rr_en = 1'b1;
      end
    end else if (!low_found) begin
      // Empty mask in MULTI is unreachable; behave as RUN so the pipe never wedges.
      bus.pc_en    = 1'b1;
      bus.if_id_en = 1'b1;
      bus.id_rr_en = 1'b1;
    end else begin
      bus.multi_valid = 1'b1;
      bus.multi_reg   = low_idx;
      bus.multi_last  = is_last;
      bus.id_rr_en    = 1'b1;
      bus.pc_en       = is_last;
      bus.if_id_en    = is_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      mask_q <= '0;
    end else if (bus.flush_req) begin
      state  <= RUN;
      mask_q <= '0;
    end else if (!bus.load_use_stall) begin
      case (state)
        RUN: begin
          if (bus.multi_start && (bus.multi_mask != '0)) begin
            mask_q <= bus.multi_mask;
            state  <= MULTI;
          end
        end
        MULTI: begin
          mask_q <= mask_rest;
          if (mask_rest == '0) state <= RUN;
        end
        default: begin
          state  <= RUN;
          mask_q <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!bus.pc_en)    stall_cnt <= stall_cnt + 32'd1;
      if (bus.flush_req) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles = rst ? 32'd0 : stall_cnt;
  assign bus.flush_count  = rst ? 32'd0 : flush_cnt;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_count  = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed vector table plus randomized run against a queue-based model
module tb_pipeline_stall_ctrl;
`ifdef PIPE_STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctl packing: {pc_en, if_id_en, if_id_flush, id_rr_en, id_rr_bubble, multi_valid, multi_last}
  localparam logic [6:0] C_ZERO  = 7'b0000000;
  localparam logic [6:0] C_RUN   = 7'b1101000;
  localparam logic [6:0] C_STALL = 7'b0001100;
  localparam logic [6:0] C_MOP   = 7'b0001010;
  localparam logic [6:0] C_MLAST = 7'b1101011;
  localparam logic [6:0] C_FLUSH = 7'b1111100;

  typedef struct {
    bit         r, f, s, st;
    logic [7:0] m;
    logic [6:0] ctl;
    logic [2:0] rg;
  } vec_t;

  logic clk;
  logic rst;
  pipeline_stall_ctrl_if #(.NREGS(8)) bus ();

  pipeline_stall_ctrl #(.NREGS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  bit          m_multi = 1'b0;
  int          m_q[$];
  logic [31:0] m_scnt = '0;
  logic [31:0] m_fcnt = '0;
  vec_t        tab[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  // Reference: LM/SM is a queue of register numbers popped one per unstalled cycle.
  task automatic model(input bit r, input bit f, input bit s, input bit st, input logic [7:0] m,
                       output logic [6:0] ctl, output logic [2:0] rg,
                       output logic [31:0] es, output logic [31:0] ef);
    bit pc, ifid, ifl, idrr, bub, v, l;
    {pc, ifid, ifl, idrr, bub, v, l} = '0;
    rg = '0;
    es = (r || !PERF) ? 32'd0 : m_scnt;
    ef = (r || !PERF) ? 32'd0 : m_fcnt;
    if (r) begin
      m_multi = 1'b0;
      m_q.delete();
      m_scnt = '0;
      m_fcnt = '0;
    end else if (f) begin
      {pc, ifid, ifl, idrr, bub} = 5'b11111;
      m_multi = 1'b0;
      m_q.delete();
      m_fcnt = m_fcnt + 1;
    end else if (s) begin
      idrr = 1'b1;
      bub  = 1'b1;
    end else if (!m_multi) begin
      if (st && m != 0) begin
        idrr = 1'b1;
        bub  = 1'b1;
        for (int i = 0; i < 8; i++) if (m[i]) m_q.push_back(i);
        m_multi = 1'b1;
      end else begin
        {pc, ifid, idrr} = 3'b111;
      end
    end else begin
      v    = 1'b1;
      rg   = 3'(m_q[0]);
      l    = (m_q.size() == 1);
      idrr = 1'b1;
      pc   = l;
      ifid = l;
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_multi = 1'b0;
    end
    if (!r && !pc) m_scnt = m_scnt + 1;
    ctl = {pc, ifid, ifl, idrr, bub, v, l};
  endtask

  task automatic step(input int idx, input bit r, input bit f, input bit s, input bit st,
                      input logic [7:0] m, input bit use_tab, input logic [6:0] tctl, input logic [2:0] trg);
    logic [6:0]  ectl;
    logic [2:0]  erg;
    logic [31:0] es, ef;
    logic [6:0]  actl;
    rst                = r;
    bus.flush_req      = f;
    bus.load_use_stall = s;
    bus.multi_start    = st;
    bus.multi_mask     = m;
    #3;
    model(r, f, s, st, m, ectl, erg, es, ef);
    if (use_tab) begin
      ectl = tctl;
      erg  = trg;
    end
    actl = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_rr_en, bus.id_rr_bubble,
            bus.multi_valid, bus.multi_last};
    chk(use_tab ? "table_ctl" : "rand_ctl", idx, 32'(actl), 32'(ectl));
    if (ectl[1]) chk(use_tab ? "table_reg" : "rand_reg", idx, 32'(bus.multi_reg), 32'(erg));
    chk("stall_cycles", idx, bus.stall_cycles, es);
    chk("flush_count", idx, bus.flush_count, ef);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit r, bit f, bit s, bit st, logic [7:0] m, logic [6:0] ctl, logic [2:0] rg);
    vec_t v;
    v.r = r; v.f = f; v.s = s; v.st = st; v.m = m; v.ctl = ctl; v.rg = rg;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    bus.flush_req = 1'b0;
    bus.load_use_stall = 1'b0;
    bus.multi_start = 1'b0;
    bus.multi_mask = '0;

    // reset held with flush asserted, then release
    tab.push_back(mk(1, 1, 0, 0, 8'h00, C_ZERO, 0));
    tab.push_back(mk(1, 1, 0, 0, 8'h00, C_ZERO, 0));
    tab.push_back(mk(0, 0, 0, 0, 8'h00, C_RUN, 0));
    // two-cycle load-use stall
    tab.push_back(mk(0, 0, 1, 0, 8'h00, C_STALL, 0));
    tab.push_back(mk(0, 0, 1, 0, 8'h00, C_STALL, 0));
    tab.push_back(mk(0, 0, 0, 0, 8'h00, C_RUN, 0));
    // LM 0x29: start, regs 0,3,5
    tab.push_back(mk(0, 0, 0, 1, 8'h29, C_STALL, 0));
    tab.push_back(mk(0, 0, 0, 1, 8'h29, C_MOP, 0));
    tab.push_back(mk(0, 0, 0, 1, 8'h29, C_MOP, 3));
    tab.push_back(mk(0, 0, 0, 1, 8'h29, C_MLAST, 5));
    tab.push_back(mk(0, 0, 0, 0, 8'h00, C_RUN, 0));
    // LM 0x06 with a stall on the first micro-op
    tab.push_back(mk(0, 0, 0, 1, 8'h06, C_STALL, 0));
    tab.push_back(mk(0, 0, 1, 1, 8'h06, C_STALL, 0));
    tab.push_back(mk(0, 0, 0, 1, 8'h06, C_MOP, 1));
    tab.push_back(mk(0, 0, 0, 1, 8'h06, C_MLAST, 2));
    tab.push_back(mk(0, 0, 0, 0, 8'h00, C_RUN, 0));
    // 0x0F with flush+stall on the second micro-op
    tab.push_back(mk(0, 0, 0, 1, 8'h0F, C_STALL, 0));
    tab.push_back(mk(0, 0, 0, 1, 8'h0F, C_MOP, 0));
    tab.push_back(mk(0, 1, 1, 1, 8'h0F, C_FLUSH, 0));
    tab.push_back(mk(0, 0, 0, 0, 8'h00, C_RUN, 0));
    // empty mask passes straight through
    tab.push_back(mk(0, 0, 0, 1, 8'h00, C_RUN, 0));
    tab.push_back(mk(0, 0, 0, 0, 8'h00, C_RUN, 0));
    // mask 0x81 order 0 then 7
    tab.push_back(mk(0, 0, 0, 1, 8'h81, C_STALL, 0));
    tab.push_back(mk(0, 0, 0, 1, 8'h81, C_MOP, 0));
    tab.push_back(mk(0, 0, 0, 1, 8'h81, C_MLAST, 7));
    // reset mid-MULTI
    tab.push_back(mk(0, 0, 0, 1, 8'h0F, C_STALL, 0));
    tab.push_back(mk(0, 0, 0, 1, 8'h0F, C_MOP, 0));
    tab.push_back(mk(1, 0, 0, 1, 8'h0F, C_ZERO, 0));
    tab.push_back(mk(0, 0, 0, 0, 8'h00, C_RUN, 0));
    tab.push_back(mk(0, 0, 0, 0, 8'h00, C_RUN, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tab.size(); i++)
      step(i, tab[i].r, tab[i].f, tab[i].s, tab[i].st, tab[i].m, 1'b1, tab[i].ctl, tab[i].rg);

    for (int i = 0; i < 600; i++) begin
      bit r, f, s, st;
      logic [7:0] m;
      r  = ($urandom_range(0, 59) == 0);
      f  = ($urandom_range(0, 11) == 0);
      s  = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 2) != 0);
      m  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      step(1000 + i, r, f, s, st, m, 1'b0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Consumer side of the hazard/stall path in the IITB-RISC 6-stage pipeline. It takes the load-use stall request from the decode-stage hazard detector, the branch/jump redirect from execute, and LM/SM multi-register requests from decode. From these it drives the pipeline-register enables, bubble and flush controls, and a per-register micro-op sequencer. Stage enables are combinational on the current state and request inputs; sequencing state is registered.

## Interface
- `NREGS`, default 8: register-file size; width of the LM/SM mask; `multi_reg` is `$clog2(NREGS)` bits.
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `load_use_stall` in 1: load-use hazard request from the decode/register-read comparison.
- `flush_req` in 1: taken branch/jump resolved in execute; PC is being redirected this cycle.
- `multi_start` in 1: decode holds an LM/SM instruction.
- `multi_mask` in NREGS: LM/SM register mask from the instruction in decode.
- `pc_en` out 1: PC register load enable.
- `if_id_en` out 1: IF/ID pipeline register enable.
- `if_id_flush` out 1: IF/ID loads a NOP.
- `id_rr_en` out 1: ID/RR pipeline register enable.
- `id_rr_bubble` out 1: ID/RR loads a NOP instead of the decode output.
- `multi_valid` out 1: a micro-op for `multi_reg` is issued into ID/RR this cycle.
- `multi_reg` out `$clog2(NREGS)`: register index of the current micro-op.
- `multi_last` out 1: current micro-op is the final one of the LM/SM.
- `stall_cycles` out 32: count of cycles with `pc_en`=0 (perf counter, see Configuration).
- `flush_count` out 32: count of accepted flushes (perf counter).

## Operation
- States:
  - **RUN**: normal flow; `pc_en`, `if_id_en` and `id_rr_en` are 1; all other outputs 0.
  - **MULTI**: LM/SM sequencing; holds `mask_q` (NREGS bits).
- Priority each cycle: `rst` > `flush_req` > `load_use_stall` > `multi_start`.
- **flush_req** in any state:
  - `pc_en`=1, `if_id_en`=1, `if_id_flush`=1, `id_rr_en`=1, `id_rr_bubble`=1.
  - Next state RUN; `mask_q` cleared. A flush aborts an in-progress LM/SM.
- **RUN + load_use_stall**:
  - `pc_en`=0, `if_id_en`=0, `id_rr_en`=1, `id_rr_bubble`=1.
  - Stays in RUN. A stall lasting N cycles inserts N bubbles.
- **RUN + multi_start**:
  - If `multi_mask`≠0: `pc_en`=0, `if_id_en`=0, `id_rr_bubble`=1; capture `mask_q`←`multi_mask`; next state MULTI.
  - If `multi_mask`=0: normal RUN outputs; the instruction passes as a single NOP-equivalent.
- **MULTI**, no flush, no stall:
  - `multi_valid`=1; `multi_reg` = index of lowest set bit of `mask_q`; that bit is cleared.
  - `id_rr_en`=1, `id_rr_bubble`=0.
  - `multi_last`=1 iff popcount(`mask_q`)=1. On the last micro-op, `pc_en`=1 and `if_id_en`=1 so the LM/SM leaves decode, and the next state is RUN. Otherwise `pc_en`=0, `if_id_en`=0.
- **MULTI + load_use_stall**: sequencer frozen (`mask_q` unchanged); `multi_valid`=0, `id_rr_bubble`=1, `pc_en`=0, `if_id_en`=0.
- `multi_start` is ignored while in MULTI.

## Timing
- Reset: state RUN, `mask_q`=0, counters 0. While `rst`=1, all outputs are 0, including all enables.
- Stall and flush take effect the same cycle as the request (combinational path to the enables).
- LM/SM with popcount P and no interference:
  - 1 start cycle + P micro-op cycles.
  - `pc_en` is low for P cycles, i.e. cycles S through S+P−1.
  - The next instruction enters decode at S+P+1.
- Mask `8'b1000_0001`:
  - Issue order is reg 0, then reg 7.
  - `multi_last` is asserted with reg 7.
- `rst` mid-MULTI returns to RUN on the next edge; no further micro-ops are issued.

## Configuration
- `PIPE_STALL_PERF_EN` defined:
  - `stall_cycles` increments every non-reset cycle with `pc_en`=0.
  - `flush_count` increments every cycle `flush_req` is accepted.
  - Both are 32-bit and wrap at 2^32.
- `PIPE_STALL_PERF_EN` undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Reset: hold `rst` for 2 cycles with `flush_req`=1. Required: all outputs 0; after release, RUN with all enables 1.
- Load-use stall held for 2 cycles. Required: `pc_en`/`if_id_en`=0 and `id_rr_bubble`=1 for exactly 2 cycles; with the perf macro defined, `stall_cycles`=2.
- LM with mask `0x29`. Required: start cycle, then `multi_reg`=0, 3, 5; `multi_last` only with 5; `pc_en`=1 at the reg-5 cycle; RUN the following cycle.
- LM with mask `0x06` and `load_use_stall` during the first micro-op. Required: reg 1 is delayed one cycle with `multi_valid`=0 during the stall, then regs 1 and 2 issue.
- `flush_req` together with `load_use_stall` on the second micro-op of mask `0x0F`. Required: flush outputs win, state goes to RUN, `mask_q`=0, `flush_count`=1.
- `multi_start` with mask `0x00`. Required: no stall, state remains RUN.
